// File: rtl/imem_loadable.sv
// imem_loadable: synchronous-read instruction memory with a valid/ready program-load port
module imem_loadable #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_oob,
  output logic [ADDR_W:0]   prog_len,
  output logic              loaded
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int PW = ADDR_W + 1;
  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic accept, term, fetch_go, in_range;
  assign accept   = load_valid & load_ready;
  assign term     = accept & (load_last | (wr_ptr == AW'(DEPTH - 1)));
  assign fetch_go = fetch_req & fetch_ready;
  // prog_len never exceeds DEPTH, so any address below it is a legal RAM index
  assign in_range = PW'(fetch_addr) < prog_len;
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx = (state == LOAD) ? (term ? RUN : LOAD)
             : load_start      ? LOAD
             : (state == RUN)  ? RUN : EMPTY;
  end
  always_comb begin
    load_ready  = state == LOAD;
    fetch_ready = state == RUN;
    loaded      = state == RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      prog_len <= '0;
    end else if (state != LOAD && load_start) begin
      wr_ptr   <= '0;
      prog_len <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (term) prog_len <= PW'(wr_ptr) + PW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= load_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_oob   <= 1'b0;
    end else begin
      instr_valid <= fetch_go;
      if (fetch_go) begin
        instr     <= in_range ? mem[fetch_addr[AW-1:0]] : '0;
        fetch_oob <= !in_range;
      end
    end
  end
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: scoreboard bench for a 256-word and a 16-word instance
module tb_imem_loadable;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;
  logic        ls_a, lv_a, ll_a, lr_a, fq_a, fr_a, iv_a, oob_a, ld_a;
  logic [15:0] dat_a, ins_a;
  logic [7:0]  fa_a;
  logic [8:0]  pl_a;
  logic        ls_b, lv_b, ll_b, lr_b, fq_b, fr_b, iv_b, oob_b, ld_b;
  logic [15:0] dat_b, ins_b;
  logic [7:0]  fa_b;
  logic [8:0]  pl_b;
  imem_loadable u_a (
    .clk(clk), .rst(rst), .load_start(ls_a), .load_valid(lv_a), .load_data(dat_a),
    .load_last(ll_a), .load_ready(lr_a), .fetch_req(fq_a), .fetch_addr(fa_a),
    .fetch_ready(fr_a), .instr(ins_a), .instr_valid(iv_a), .fetch_oob(oob_a),
    .prog_len(pl_a), .loaded(ld_a)
  );
  imem_loadable #(.DEPTH(16)) u_b (
    .clk(clk), .rst(rst), .load_start(ls_b), .load_valid(lv_b), .load_data(dat_b),
    .load_last(ll_b), .load_ready(lr_b), .fetch_req(fq_b), .fetch_addr(fa_b),
    .fetch_ready(fr_b), .instr(ins_b), .instr_valid(iv_b), .fetch_oob(oob_b),
    .prog_len(pl_b), .loaded(ld_b)
  );
  int vecs = 0, errs = 0;
  logic [16:0] qa[$], qb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // monitors: every instr_valid pulse must match the oldest expected response
  always @(negedge clk) begin
    if (iv_a === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_valid", {15'b0, ins_a, oob_a}, 32'hffff_ffff);
      else chk("a_fetch", {15'b0, ins_a, oob_a}, {15'b0, qa.pop_front()});
    end
    if (iv_b === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_valid", {15'b0, ins_b, oob_b}, 32'hffff_ffff);
      else chk("b_fetch", {15'b0, ins_b, oob_b}, {15'b0, qb.pop_front()});
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_a(input logic [7:0] a, input logic [15:0] d, input logic o);
    fq_a = 1; fa_a = a; qa.push_back({d, o});
    tick;
    fq_a = 0;
  endtask
  task automatic load_a(input int n, input logic [15:0] base);
    ls_a = 1;
    tick;
    ls_a = 0;
    for (int i = 0; i < n; i++) begin
      lv_a = 1; dat_a = base + 16'(i); ll_a = (i == n - 1);
      tick;
    end
    lv_a = 0; ll_a = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int acc;
    rst = 1;
    {ls_a, lv_a, ll_a, fq_a, ls_b, lv_b, ll_b, fq_b} = '0;
    dat_a = 0; dat_b = 0; fa_a = 0; fa_b = 0;
    tick; tick;
    rst = 0;
    chk("rst_state", {pl_a, ins_a, iv_a, oob_a, ld_a, lr_a, fr_a}, 32'h0);
    chk("rst_state_b", {pl_b, ins_b, iv_b, oob_b, ld_b, lr_b, fr_b}, 32'h0);
    fq_a = 1; fa_a = 0;
    for (int i = 0; i < 3; i++) begin
      chk("empty_fetch_ready", {31'b0, fr_a}, 0);
      tick;
    end
    fq_a = 0;
    chk("empty_instr", {16'b0, ins_a}, 0);
    chk("empty_loaded", {31'b0, ld_a}, 0);
    load_a(14, 16'h1000);
    chk("load14_len", {23'b0, pl_a}, 14);
    chk("load14_loaded", {30'b0, ld_a, fr_a}, 3);
    fetch_a(5, 16'h1005, 0);
    fetch_a(13, 16'h100d, 0);
    fq_a = 1; fa_a = 14; qa.push_back({16'h0, 1'b1});
    tick;
    fa_a = 255; qa.push_back({16'h0, 1'b1});
    tick;
    fq_a = 0;
    tick;
    load_a(8, 16'h2000);
    chk("load8_len", {23'b0, pl_a}, 8);
    ls_a = 1;
    tick;
    ls_a = 0;
    for (int i = 0; i < 3; i++) begin
      lv_a = 1; dat_a = 16'h4000 + 16'(i);
      tick;
    end
    lv_a = 0; rst = 1;
    tick;
    rst = 0;
    chk("midload_rst", {pl_a, ld_a, lr_a}, 0);
    load_a(2, 16'h3000);
    chk("load2_len", {23'b0, pl_a}, 2);
    fetch_a(2, 16'h0, 1);
    fetch_a(1, 16'h3001, 0);
    load_a(6, 16'h5000);
    ls_a = 1; fq_a = 1; fa_a = 3; qa.push_back({16'h5003, 1'b0});
    tick;
    ls_a = 0; fq_a = 0;
    chk("reload_in_load", {30'b0, lr_a, fr_a}, 2);
    for (int i = 0; i < 4; i++) begin
      lv_a = 1; dat_a = (i == 3) ? 16'hbeef : 16'ha000 + 16'(i); ll_a = (i == 3);
      tick;
    end
    lv_a = 0; ll_a = 0;
    fetch_a(3, 16'hbeef, 0);
    fetch_a(4, 16'h0, 1);
    ls_b = 1;
    tick;
    ls_b = 0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      lv_b = 1; dat_b = 16'h7000 + 16'(i);
      if (lr_b) acc++;
      tick;
    end
    lv_b = 0;
    chk("full_accepted", 32'(acc), 16);
    chk("full_ready_low", {31'b0, lr_b}, 0);
    chk("full_len", {23'b0, pl_b}, 16);
    fq_b = 1; fa_b = 15; qb.push_back({16'h700f, 1'b0});
    tick;
    fa_b = 16; qb.push_back({16'h0, 1'b1});
    tick;
    fa_b = 200; qb.push_back({16'h0, 1'b1});
    tick;
    fq_b = 0;
    tick; tick;
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
